proc_io_hub: RTL and testbench

Buffered, parametrised I/O hub between a `proc_fx` core and its external channels, replacing the bare one-hot address decoders on `proc_req_in`/`proc_out_en`. Each input and output channel gets a FIFO with valid/ready handshaking, so external producers and consumers need not be ready on the exact cycle the processor executes its I/O instruction. Sticky per-channel underflow and overflow flags report lost or missing words. It sits at the top level, beside the processor, in place of the `addr_dec` pair.

---
 rtl/proc_io_hub.sv | 136 +++++++++++++
 tb/tb_proc_io_hub.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_io_hub.sv
`default_nettype none
// ============================================================================
//  Module      : proc_io_hub
//  Description : Per-channel FIFO-buffered I/O hub between proc_fx and its
//                external valid/ready channels, with sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module proc_io_hub #(
  parameter int NUBITS = 31,
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int FDEPTH = 4,
  localparam int AWIN = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int AWOU = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_req_in,
  input  logic [AWIN-1:0]          addr_in,
  output logic [NUBITS-1:0]        proc_din,
  input  logic                     proc_out_en,
  input  logic [AWOU-1:0]          addr_out,
  input  logic [NUBITS-1:0]        proc_dout,
  input  logic [NUIOIN*NUBITS-1:0] ext_in_data,
  input  logic [NUIOIN-1:0]        ext_in_valid,
  output logic [NUIOIN-1:0]        ext_in_ready,
  output logic [NUIOOU*NUBITS-1:0] ext_out_data,
  output logic [NUIOOU-1:0]        ext_out_valid,
  input  logic [NUIOOU-1:0]        ext_out_ready,
  output logic [NUIOIN-1:0]        req_in,
  output logic [NUIOOU-1:0]        out_en,
  output logic [NUIOIN-1:0]        in_underflow,
  output logic [NUIOOU-1:0]        out_overflow,
  input  logic                     err_clr
);

  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_full = CW'(FDEPTH);

  logic [NUBITS-1:0] w_in_rdval [NUIOIN];

  // Input channels: external producer pushes, processor read pops.
  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    logic [NUBITS-1:0] r_mem [FDEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic [NUBITS-1:0] r_last;
    logic              r_uf;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;

    assign req_in[k]       = proc_req_in & (addr_in == AWIN'(k));
    assign w_empty         = (r_cnt == '0);
    assign ext_in_ready[k] = (r_cnt < c_full);
    assign w_push          = ext_in_valid[k] & ext_in_ready[k];
    assign w_pop           = req_in[k] & ~w_empty;
    // An empty read repeats the last word the processor consumed.
    assign w_in_rdval[k]   = w_empty ? r_last : r_mem[r_rd_ptr];
    assign in_underflow[k] = r_uf;

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= ext_in_data[k*NUBITS +: NUBITS];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
        r_last   <= '0;
        r_uf     <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
          r_last   <= r_mem[r_rd_ptr];
        end
        if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
        else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
        r_uf <= (req_in[k] & w_empty) | (r_uf & ~err_clr);
      end
    end
  end

  always_comb begin
    proc_din = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (req_in[k]) proc_din = w_in_rdval[k];
    end
  end

  // Output channels: processor write pushes, external consumer pops.
  for (genvar j = 0; j < NUIOOU; j++) begin : g_out
    logic [NUBITS-1:0] r_mem [FDEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic              r_ov;
    logic              w_push;
    logic              w_pop;
    logic              w_room;

    assign out_en[j]        = proc_out_en & (addr_out == AWOU'(j));
    assign ext_out_valid[j] = (r_cnt != '0);
    assign w_pop            = ext_out_valid[j] & ext_out_ready[j];
    // A same-cycle pop frees the slot the write lands in, so a full FIFO still accepts.
    assign w_room           = (r_cnt < c_full) | w_pop;
    assign w_push           = out_en[j] & w_room;
    assign ext_out_data[j*NUBITS +: NUBITS] = r_mem[r_rd_ptr];
    assign out_overflow[j]  = r_ov;

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= proc_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
        r_ov     <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
        else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
        r_ov <= (out_en[j] & ~w_room) | (r_ov & ~err_clr);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_io_hub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_proc_io_hub
//  Description : Directed self-checking bench for proc_io_hub.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_io_hub;
  localparam int NB = 31;

  logic             clk = 1'b0;
  logic             rst;
  logic             proc_req_in;
  logic [1:0]       addr_in;
  logic [NB-1:0]    proc_din;
  logic             proc_out_en;
  logic [1:0]       addr_out;
  logic [NB-1:0]    proc_dout;
  logic [4*NB-1:0]  ext_in_data;
  logic [3:0]       ext_in_valid;
  logic [3:0]       ext_in_ready;
  logic [4*NB-1:0]  ext_out_data;
  logic [3:0]       ext_out_valid;
  logic [3:0]       ext_out_ready;
  logic [3:0]       req_in;
  logic [3:0]       out_en;
  logic [3:0]       in_underflow;
  logic [3:0]       out_overflow;
  logic             err_clr;

  logic [NB-1:0]    b_proc_din;
  logic [2:0]       b_ext_in_ready;
  logic [3*NB-1:0]  b_ext_out_data;
  logic [2:0]       b_ext_out_valid;
  logic [2:0]       b_req_in;
  logic [2:0]       b_out_en;
  logic [2:0]       b_in_underflow;
  logic [2:0]       b_out_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  proc_io_hub u_dut (
    .clk(clk), .rst(rst),
    .proc_req_in(proc_req_in), .addr_in(addr_in), .proc_din(proc_din),
    .proc_out_en(proc_out_en), .addr_out(addr_out), .proc_dout(proc_dout),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .req_in(req_in), .out_en(out_en),
    .in_underflow(in_underflow), .out_overflow(out_overflow), .err_clr(err_clr)
  );

  // Three-channel instance sees the same strobes; address 3 is out of range for it.
  proc_io_hub #(.NUIOIN(3), .NUIOOU(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .proc_req_in(proc_req_in), .addr_in(addr_in), .proc_din(b_proc_din),
    .proc_out_en(proc_out_en), .addr_out(addr_out), .proc_dout(proc_dout),
    .ext_in_data(ext_in_data[3*NB-1:0]), .ext_in_valid(ext_in_valid[2:0]),
    .ext_in_ready(b_ext_in_ready),
    .ext_out_data(b_ext_out_data), .ext_out_valid(b_ext_out_valid),
    .ext_out_ready(ext_out_ready[2:0]),
    .req_in(b_req_in), .out_en(b_out_en),
    .in_underflow(b_in_underflow), .out_overflow(b_out_overflow), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; proc_req_in = 1'b0; addr_in = '0; proc_out_en = 1'b0; addr_out = '0;
    proc_dout = '0; ext_in_data = '0; ext_in_valid = '0; ext_out_ready = '0; err_clr = 1'b0;
    #2;
    chk("rst_in_ready", 64'(ext_in_ready), 64'hF);
    chk("rst_out_valid", 64'(ext_out_valid), 64'h0);
    chk("rst_flags", 64'({in_underflow, out_overflow}), 64'h0);
    chk("rst_din_idle", 64'(proc_din), 64'h0);
    proc_req_in = 1'b1; addr_in = 2'd2;
    #1;
    chk("rst_din_read", 64'(proc_din), 64'h0);
    proc_req_in = 1'b0;
    #9 rst = 1'b0;
    tick();

    // Out-of-range address on the three-channel instance
    proc_req_in = 1'b1; addr_in = 2'd3; proc_out_en = 1'b1; addr_out = 2'd3; proc_dout = NB'('h55);
    #1;
    chk("oor_din", 64'(b_proc_din), 64'h0);
    chk("oor_req_in", 64'(b_req_in), 64'h0);
    chk("oor_out_en", 64'(b_out_en), 64'h0);
    chk("dec_req_in", 64'(req_in), 64'h8);
    chk("dec_out_en", 64'(out_en), 64'h8);
    tick();
    proc_req_in = 1'b0; proc_out_en = 1'b0;
    #1;
    chk("oor_state", 64'({b_ext_out_valid, b_ext_in_ready, b_in_underflow, b_out_overflow}),
        64'({3'b000, 3'b111, 3'b000, 3'b000}));
    chk("a_ch3_written", 64'(ext_out_valid), 64'h8);
    chk("a_ch3_data", 64'(ext_out_data[3*NB +: NB]), 64'h55);

    // Async reset mid-stream, asserted between edges
    tick();
    rst = 1'b1;
    #2;
    chk("arst_out_valid", 64'(ext_out_valid), 64'h0);
    chk("arst_underflow", 64'(in_underflow), 64'h0);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 64'(ext_in_ready), 64'hF);
    tick();

    // Input fill and drain, channel 2
    ext_in_valid[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ext_in_data[2*NB +: NB] = NB'(32'h11 + i);
      #1;
      chk($sformatf("fill_ready%0d", i), 64'(ext_in_ready[2]), 64'(i < 4));
      tick();
    end
    proc_req_in = 1'b1; addr_in = 2'd2;
    for (int r = 0; r < 5; r++) begin
      logic pushed;
      #1;
      chk($sformatf("drain%0d", r), 64'(proc_din), 64'(32'h11 + r));
      pushed = ext_in_valid[2] & ext_in_ready[2];
      tick();
      if (pushed) ext_in_valid[2] = 1'b0;
    end
    proc_req_in = 1'b0;
    #1;
    chk("drain_idle_din", 64'(proc_din), 64'h0);
    chk("drain_no_uf", 64'(in_underflow), 64'h0);

    // Underflow on channel 1
    ext_in_valid[1] = 1'b1; ext_in_data[NB +: NB] = NB'('h7);
    tick();
    ext_in_valid[1] = 1'b0;
    proc_req_in = 1'b1; addr_in = 2'd1;
    #1;
    chk("uf_first", 64'(proc_din), 64'h7);
    tick();
    chk("uf_empty_last", 64'(proc_din), 64'h7);
    tick();
    proc_req_in = 1'b0;
    chk("uf_set", 64'(in_underflow), 64'h2);
    tick(); tick();
    chk("uf_sticky", 64'(in_underflow), 64'h2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("uf_clear", 64'(in_underflow), 64'h0);
    proc_req_in = 1'b1; err_clr = 1'b1;
    tick();
    proc_req_in = 1'b0; err_clr = 1'b0;
    chk("uf_set_wins", 64'(in_underflow), 64'h2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Output overflow with backpressure on channel 3
    proc_out_en = 1'b1; addr_out = 2'd3;
    for (int i = 0; i < 5; i++) begin
      proc_dout = NB'(32'hA0 + i);
      tick();
    end
    proc_out_en = 1'b0;
    chk("ov_set", 64'(out_overflow), 64'h8);
    ext_out_ready[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ov_drain%0d", i), 64'({ext_out_valid[3], ext_out_data[3*NB +: NB]}),
          64'({1'b1, NB'(32'hA0 + i)}));
      tick();
    end
    chk("ov_empty", 64'(ext_out_valid[3]), 64'h0);
    ext_out_ready[3] = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Full output FIFO: write and pop in the same cycle
    proc_out_en = 1'b1; addr_out = 2'd0;
    for (int i = 0; i < 4; i++) begin
      proc_dout = NB'(32'hB0 + i);
      tick();
    end
    ext_out_ready[0] = 1'b1; proc_dout = NB'('hB4);
    #1;
    chk("sim_out_head", 64'(ext_out_data[NB-1:0]), 64'hB0);
    tick();
    proc_out_en = 1'b0;
    chk("sim_out_no_ov", 64'(out_overflow), 64'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("sim_out%0d", i), 64'({ext_out_valid[0], ext_out_data[NB-1:0]}),
          64'({1'b1, NB'(32'hB1 + i)}));
      tick();
    end
    chk("sim_out_empty", 64'(ext_out_valid[0]), 64'h0);

    // Empty input FIFO: push and read in the same cycle
    ext_in_valid[0] = 1'b1; ext_in_data[NB-1:0] = NB'('h33);
    proc_req_in = 1'b1; addr_in = 2'd0;
    #1;
    chk("sim_in_last", 64'(proc_din), 64'h0);
    tick();
    ext_in_valid[0] = 1'b0;
    chk("sim_in_uf", 64'(in_underflow), 64'h1);
    chk("sim_in_data", 64'(proc_din), 64'h33);
    tick();
    proc_req_in = 1'b0;
    chk("sim_in_drained", 64'(ext_in_ready[0]), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
